// File: rtl/dp_pkg.sv
// dp_pkg
//   Shared definitions for the unary product array and its dot-product
//   collector: the collector state encoding and helpers that derive the
//   adder-tree and accumulator widths from the lane operand width and the
//   number of lanes.
package dp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } dp_state_e;

  // Width of the popcount of num_prods single-bit lane outputs.
  function automatic int dp_tree_w(input int num_prods);
    return $clog2(num_prods + 1);
  endfunction

  // Every lane contributes at most (2^width-1)^2 ones per op, so the sum of
  // num_prods lanes fits in tree width + 2*width bits.
  function automatic int dp_acc_w(input int width, input int num_prods);
    return dp_tree_w(num_prods) + 2 * width;
  endfunction

endpackage

// File: rtl/dot_product_collector_sat_accumulator.sv
// sat_accumulator
//   Saturating binary accumulator. Adds a zero-extended IN_W-bit value to an
//   ACC_W-bit running total each enabled cycle; on overflow the total clips at
//   all-ones and a sticky saturation flag is raised until the next clear.
// Ports
//   clk       in   clock
//   reset     in   synchronous active-high reset (total and flag to 0)
//   clear     in   start a new accumulation (wins over en)
//   en        in   add `in` this cycle
//   in        in   IN_W   value to add
//   acc       out  ACC_W  registered running total
//   sat_flag  out  registered sticky overflow flag
module sat_accumulator #(
  parameter int IN_W  = 5,
  parameter int ACC_W = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [IN_W-1:0]  in,
  output logic [ACC_W-1:0] acc,
  output logic             sat_flag
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic [ACC_W:0]   sum_wide;

  always_comb begin
    // One extra bit catches the carry out of the ACC_W-bit add.
    sum_wide = {1'b0, acc_q} + (ACC_W + 1)'(in);
    acc_d    = acc_q;
    sat_d    = sat_q;
    if (clear) begin
      acc_d = '0;
      sat_d = 1'b0;
    end else if (en) begin
      if (sum_wide[ACC_W]) begin
        acc_d = '1;
        sat_d = 1'b1;
      end else begin
        acc_d = sum_wide[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

  assign acc      = acc_q;
  assign sat_flag = sat_q;

endmodule

// File: rtl/dot_product_collector.sv
// dot_product_collector
//   Downstream stage of the unary product array. Integrates the per-cycle
//   popcount of all lane outputs into a binary dot product, detects when every
//   enabled lane has finished, and presents result plus status on a
//   valid/ready output. A cycle-count watchdog ends ops whose lanes never
//   report done.
// Ports
//   clk, reset     clock and synchronous active-high reset
//   start          launch an op (same cycle the lanes see their input)
//   lane_mask      lanes taking part, captured when start is accepted
//   start_ready    start is accepted this cycle
//   lane_done      per-lane done flags
//   tree_sum       popcount of the lane unary outputs this cycle
//   result_valid   result/status valid (held until result_ready)
//   result_ready   consumer accepts the result
//   result         accumulated dot product
//   cycles         ACCUM cycles spent on the op
//   timeout        op ended by the watchdog
//   saturated      accumulator clipped at all-ones during the op
//   busy           collector is not idle
module dot_product_collector
  import dp_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int NUM_PRODS  = 16,
  parameter int TREE_W     = dp_tree_w(NUM_PRODS),
  parameter int ACC_W      = dp_acc_w(WIDTH, NUM_PRODS),
  parameter int MAX_CYCLES = 256,
  parameter int CNT_W      = $clog2(MAX_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_PRODS-1:0] lane_mask,
  output logic                 start_ready,
  input  logic [NUM_PRODS-1:0] lane_done,
  input  logic [TREE_W-1:0]    tree_sum,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [ACC_W-1:0]     result,
  output logic [CNT_W-1:0]     cycles,
  output logic                 timeout,
  output logic                 saturated,
  output logic                 busy
);

  // Value of the cycle counter during the last cycle the watchdog allows.
  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

  dp_state_e            state_q, state_d;
  logic [NUM_PRODS-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]     cycles_q, cycles_d;
  logic                 timeout_q, timeout_d;
  logic                 result_valid_q, result_valid_d;

  logic                 all_done;
  logic                 accept_start;
  logic                 acc_clear;
  logic                 acc_en;

  // Masked-off lanes count as done, so an empty mask completes immediately.
  assign all_done     = &(lane_done | ~mask_q);
  assign start_ready  = (state_q == ST_IDLE) ||
                        ((state_q == ST_HOLD) && result_ready);
  assign accept_start = start && start_ready;

  always_comb begin
    state_d        = state_q;
    mask_d         = mask_q;
    cycles_d       = cycles_q;
    timeout_d      = timeout_q;
    result_valid_d = result_valid_q;
    acc_clear      = 1'b0;
    acc_en         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Launch is handled below, shared with the back-to-back path.
      end
      ST_ACCUM: begin
        // The completion cycle still carries the lanes' last output.
        acc_en   = 1'b1;
        cycles_d = cycles_q + CNT_W'(1);
        if (all_done) begin
          state_d        = ST_HOLD;
          result_valid_d = 1'b1;
        end else if (cycles_q == LAST_CYCLE) begin
          state_d        = ST_HOLD;
          timeout_d      = 1'b1;
          result_valid_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (result_ready) begin
          state_d        = ST_IDLE;
          result_valid_d = 1'b0;
        end
      end
      default: begin
        state_d        = ST_IDLE;
        result_valid_d = 1'b0;
      end
    endcase

    // start_ready already restricts this to IDLE or an accepted HOLD.
    if (accept_start) begin
      state_d        = ST_ACCUM;
      mask_d         = lane_mask;
      cycles_d       = '0;
      timeout_d      = 1'b0;
      result_valid_d = 1'b0;
      acc_clear      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      mask_q         <= '0;
      cycles_q       <= '0;
      timeout_q      <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      mask_q         <= mask_d;
      cycles_q       <= cycles_d;
      timeout_q      <= timeout_d;
      result_valid_q <= result_valid_d;
    end
  end

  sat_accumulator #(
    .IN_W  (TREE_W),
    .ACC_W (ACC_W)
  ) u_acc (
    .clk      (clk),
    .reset    (reset),
    .clear    (acc_clear),
    .en       (acc_en),
    .in       (tree_sum),
    .acc      (result),
    .sat_flag (saturated)
  );

  assign result_valid = result_valid_q;
  assign cycles       = cycles_q;
  assign timeout      = timeout_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dot_product_collector.sv
module tb_dot_product_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] lane_mask;
  logic [15:0] lane_done;
  logic [4:0]  tree_sum;
  logic        result_ready;

  logic        start_ready, result_valid, timeout, saturated, busy;
  logic [12:0] result;
  logic [8:0]  cycles;

  logic        s_start_ready, s_result_valid, s_timeout, s_saturated, s_busy;
  logic [5:0]  s_result;
  logic [8:0]  s_cycles;

  int checks = 0;
  int errors = 0;

  // Lane stimulus model: lane i runs lw[i]*16 cycles, emitting a one in the
  // first lx[i] cycles of every 16-cycle block, and raises done in its last
  // cycle. A never-done lane (nd) keeps emitting its pattern forever.
  int lw[16];
  int lx[16];
  bit nd[16];
  int poke_t = -1;

  always #5 clk = ~clk;

  dot_product_collector dut (
    .clk(clk), .reset(reset), .start(start), .lane_mask(lane_mask),
    .start_ready(start_ready), .lane_done(lane_done), .tree_sum(tree_sum),
    .result_valid(result_valid), .result_ready(result_ready), .result(result),
    .cycles(cycles), .timeout(timeout), .saturated(saturated), .busy(busy)
  );

  dot_product_collector #(.ACC_W(6)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .lane_mask(lane_mask),
    .start_ready(s_start_ready), .lane_done(lane_done), .tree_sum(tree_sum),
    .result_valid(s_result_valid), .result_ready(result_ready), .result(s_result),
    .cycles(s_cycles), .timeout(s_timeout), .saturated(s_saturated), .busy(s_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input int w, input int x, input logic [15:0] which);
    for (int i = 0; i < 16; i++) begin
      lw[i] = which[i] ? w : 0;
      lx[i] = which[i] ? x : 0;
      nd[i] = 1'b0;
    end
  endtask

  task automatic drive_lanes(input int t);
    int s;
    logic [15:0] d;
    s = 0;
    d = '0;
    for (int i = 0; i < 16; i++) begin
      bit act;
      act = nd[i] || (t < lw[i] * 16);
      if (act && ((t % 16) < lx[i])) s++;
      d[i] = !nd[i] && (t >= lw[i] * 16 - 1);
    end
    tree_sum  = 5'(s);
    lane_done = d;
  endtask

  task automatic idle_lanes();
    tree_sum  = '0;
    lane_done = '0;
  endtask

  // Drives lanes cycle by cycle until result_valid rises or max cycles pass.
  task automatic run_accum(input int max, output int n, output bit got);
    got = 1'b0;
    n   = 0;
    for (int t = 0; t < max; t++) begin
      drive_lanes(t);
      if (t == poke_t) begin
        start     = 1'b1;
        lane_mask = 16'h0000;
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
      if (result_valid) begin
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
    idle_lanes();
  endtask

  task automatic run_op(input logic [15:0] m, input int max, output int n, output bit got);
    start     = 1'b1;
    lane_mask = m;
    tick();
    start = 1'b0;
    run_accum(max, n, got);
  endtask

  task automatic release_result();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick(); tick();
    reset = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || result !== 13'd0 || cycles !== 9'd0 ||
        timeout !== 1'b0 || saturated !== 1'b0 || start_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%b busy=%b result=%0d cycles=%0d to=%b sat=%b rdy=%b, required 0 0 0 0 0 0 1",
               result_valid, busy, result, cycles, timeout, saturated, start_ready);
    end
    checks++;
    if (s_result_valid !== 1'b0 || s_busy !== 1'b0 || s_result !== 6'd0 || s_saturated !== 1'b0) begin
      errors++;
      $display("FAIL reset_state_sat: valid=%b busy=%b result=%0d sat=%b, required 0 0 0 0",
               s_result_valid, s_busy, s_result, s_saturated);
    end
  endtask

  task automatic test_full_mask();
    int n;
    bit got;
    set_lanes(3, 5, 16'hFFFF);
    run_op(16'hFFFF, 300, n, got);
    checks++;
    if (!got || n != 48) begin
      errors++;
      $display("FAIL full_latency: valid=%b after %0d cycles, required valid after 48", got, n);
    end
    checks++;
    if (result !== 13'd240 || cycles !== 9'd48 || timeout !== 1'b0 || saturated !== 1'b0) begin
      errors++;
      $display("FAIL full_result: result=%0d cycles=%0d to=%b sat=%b, required 240 48 0 0",
               result, cycles, timeout, saturated);
    end
    checks++;
    if (s_result !== 6'd63 || s_saturated !== 1'b1) begin
      errors++;
      $display("FAIL full_sat6: result=%0d sat=%b, required 63 1", s_result, s_saturated);
    end
    for (int k = 0; k < 3; k++) tick();
    checks++;
    if (result_valid !== 1'b1 || result !== 13'd240 || start_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_hold: valid=%b result=%0d rdy=%b, required 1 240 0",
               result_valid, result, start_ready);
    end
    result_ready = 1'b1;
    #1;
    checks++;
    if (start_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_start_ready: start_ready=%b, required 1", start_ready);
    end
    tick();
    result_ready = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_release: valid=%b busy=%b, required 0 0", result_valid, busy);
    end
    $display("op full_mask: result=%0d cycles=%0d", 240, 48);
  endtask

  task automatic test_single_lane();
    int n;
    bit got;
    set_lanes(15, 15, 16'h0001);
    poke_t = 5;
    run_op(16'h0001, 300, n, got);
    poke_t = -1;
    checks++;
    if (!got || result !== 13'd225 || cycles !== 9'd240 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL single_lane: valid=%b result=%0d cycles=%0d to=%b, required 1 225 240 0",
               got, result, cycles, timeout);
    end
    release_result();
    $display("op single_lane: result=%0d cycles=%0d", result, cycles);
  endtask

  task automatic test_zero_mask();
    set_lanes(0, 0, 16'h0000);
    start     = 1'b1;
    lane_mask = 16'h0000;
    tick();
    start = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_mask_accum: valid=%b busy=%b, required 0 1", result_valid, busy);
    end
    drive_lanes(0);
    tick();
    idle_lanes();
    checks++;
    if (result_valid !== 1'b1 || result !== 13'd0 || cycles !== 9'd1 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL zero_mask: valid=%b result=%0d cycles=%0d to=%b, required 1 0 1 0",
               result_valid, result, cycles, timeout);
    end
    release_result();
    $display("op zero_mask: result=0 cycles=1");
  endtask

  task automatic test_timeout();
    int n;
    bit got;
    set_lanes(15, 5, 16'h0001);
    nd[0] = 1'b1;
    run_op(16'h0001, 300, n, got);
    checks++;
    if (!got || n != 256) begin
      errors++;
      $display("FAIL timeout_latency: valid=%b after %0d cycles, required valid after 256", got, n);
    end
    checks++;
    if (timeout !== 1'b1 || result !== 13'd80 || cycles !== 9'd256 || saturated !== 1'b0) begin
      errors++;
      $display("FAIL timeout_status: to=%b result=%0d cycles=%0d sat=%b, required 1 80 256 0",
               timeout, result, cycles, saturated);
    end
    release_result();
    nd[0] = 1'b0;
    $display("op timeout: result=80 cycles=256 timeout=1");
  endtask

  task automatic test_saturation();
    int n;
    bit got;
    set_lanes(3, 3, 16'hFFFF);
    run_op(16'hFFFF, 300, n, got);
    checks++;
    if (!got || s_result !== 6'd63 || s_saturated !== 1'b1 || s_cycles !== 9'd48 || s_timeout !== 1'b0) begin
      errors++;
      $display("FAIL saturation: valid=%b result=%0d sat=%b cycles=%0d to=%b, required 1 63 1 48 0",
               got, s_result, s_saturated, s_cycles, s_timeout);
    end
    checks++;
    if (result !== 13'd144 || saturated !== 1'b0) begin
      errors++;
      $display("FAIL no_saturation: result=%0d sat=%b, required 144 0", result, saturated);
    end
    release_result();
    $display("op saturation: result6=63 result13=144");
  endtask

  task automatic test_back_to_back();
    int n;
    bit got;
    set_lanes(1, 4, 16'h0001);
    run_op(16'h0001, 100, n, got);
    checks++;
    if (!got || result !== 13'd4 || cycles !== 9'd16) begin
      errors++;
      $display("FAIL b2b_first: valid=%b result=%0d cycles=%0d, required 1 4 16", got, result, cycles);
    end
    for (int k = 0; k < 10; k++) begin
      start     = k[0];
      lane_mask = 16'h0000;
      tree_sum  = 5'd7;
      tick();
      checks++;
      if (result_valid !== 1'b1 || result !== 13'd4 || cycles !== 9'd16 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL b2b_stable[%0d]: valid=%b result=%0d cycles=%0d to=%b, required 1 4 16 0",
                 k, result_valid, result, cycles, timeout);
      end
    end
    tree_sum = '0;
    set_lanes(2, 2, 16'h0003);
    result_ready = 1'b1;
    start        = 1'b1;
    lane_mask    = 16'h0003;
    #1;
    checks++;
    if (start_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: start_ready=%b, required 1", start_ready);
    end
    tick();
    start        = 1'b0;
    result_ready = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart: valid=%b busy=%b, required 0 1", result_valid, busy);
    end
    run_accum(100, n, got);
    checks++;
    if (!got || n != 32 || result !== 13'd8 || cycles !== 9'd32) begin
      errors++;
      $display("FAIL b2b_second: valid=%b n=%0d result=%0d cycles=%0d, required 1 32 8 32",
               got, n, result, cycles);
    end
    release_result();
    $display("op back_to_back: result=8 cycles=32");
  endtask

  task automatic test_reset_mid();
    bit seen;
    set_lanes(3, 5, 16'hFFFF);
    start     = 1'b1;
    lane_mask = 16'hFFFF;
    tick();
    start = 1'b0;
    for (int t = 0; t < 10; t++) begin
      drive_lanes(t);
      tick();
    end
    reset = 1'b1;
    drive_lanes(10);
    tick();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 13'd0 || cycles !== 9'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b valid=%b result=%0d cycles=%0d, required 0 0 0 0",
               busy, result_valid, result, cycles);
    end
    seen = 1'b0;
    for (int t = 11; t < 70; t++) begin
      drive_lanes(t);
      tick();
      if (result_valid === 1'b1) seen = 1'b1;
    end
    idle_lanes();
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_novalid: result_valid seen=%b, required 0", seen);
    end
    $display("op reset_mid: aborted");
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    lane_mask    = '0;
    result_ready = 1'b0;
    idle_lanes();
    set_lanes(0, 0, 16'h0000);
    test_reset();
    test_full_mask();
    test_single_lane();
    test_zero_mask();
    test_timeout();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
